// File: rtl/psdsqrt_seq.sv
// Sequential restoring integer square root: one root bit per clock, floor or
// round-to-nearest result, remainder always relative to the floor root.
module psdsqrt_seq #(
    parameter  int XW = 64,
    localparam int NW = $clog2(XW) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [NW-1:0]     nbits,
    input  logic [XW-1:0]     xin,
    input  logic              round,
    output logic              busy,
    output logic              done,
    output logic [XW/2-1:0]   sqrt,
    output logic [XW/2:0]     rem,
    output logic              err
);
    localparam int HW = XW / 2;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t          r_state, w_next;
    logic [XW-1:0]   r_x;
    logic [HW+1:0]   r_rem;
    logic [HW-1:0]   r_root;
    logic [NW-1:0]   r_k;
    logic            r_round, r_perr, r_done, r_err;
    logic [HW-1:0]   r_sqrt;
    logic [HW:0]     r_rem_o;

    logic            w_bad;
    logic [NW-1:0]   w_n;
    logic [XW-1:0]   w_xal;
    logic [HW+1:0]   w_pr, w_t, w_sub;
    logic            w_ge, w_inc;

    // Out-of-range widths fall back to the full operand width.
    assign w_bad = (nbits == '0) || (nbits > NW'(XW));
    assign w_n   = w_bad ? NW'(XW) : ((nbits + NW'(1)) & ~NW'(1));
    // Left-aligning the operand drops every bit at or above N.
    assign w_xal = xin << (NW'(XW) - w_n);

    assign w_pr  = {r_rem[HW-1:0], r_x[XW-1 -: 2]};
    assign w_t   = {r_root, 2'b01};
    assign w_ge  = (w_pr >= w_t);
    assign w_sub = w_ge ? (w_pr - w_t) : w_pr;
    assign w_inc = r_round && (r_rem > {2'b00, r_root});

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign sqrt = r_sqrt;
    assign rem  = r_rem_o;
    assign err  = r_err;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (r_k == NW'(1)) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_x     <= '0;
            r_rem   <= '0;
            r_root  <= '0;
            r_k     <= '0;
            r_round <= 1'b0;
            r_perr  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_sqrt  <= '0;
            r_rem_o <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (start) begin
                    r_x     <= w_xal;
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_k     <= w_n >> 1;
                    r_round <= round;
                    r_perr  <= w_bad;
                end
                RUN: begin
                    r_x    <= {r_x[XW-3:0], 2'b00};
                    r_rem  <= w_sub;
                    r_root <= {r_root[HW-2:0], w_ge};
                    r_k    <= r_k - NW'(1);
                end
                FIN: begin
                    r_rem_o <= r_rem[HW:0];
                    // Rounding up saturates rather than wrapping to zero.
                    r_sqrt  <= (w_inc && !(&r_root)) ? r_root + HW'(1) : r_root;
                    r_err   <= r_perr;
                    r_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_psdsqrt_seq.sv
// Directed bench for psdsqrt_seq: expected results are queued at issue time
// and a negedge monitor compares them against each done pulse.
module tb_psdsqrt_seq;
    localparam int XW = 64;
    localparam int NW = $clog2(XW) + 1;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [NW-1:0]     nbits = '0;
    logic [XW-1:0]     xin = '0;
    logic              round = 1'b0;
    logic              busy, done, err;
    logic [XW/2-1:0]   sqrt;
    logic [XW/2:0]     rem;

    typedef struct {
        logic [31:0] s;
        logic [32:0] r;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    psdsqrt_seq #(.XW(XW)) dut (
        .clock(clock), .reset(reset), .start(start), .nbits(nbits),
        .xin(xin), .round(round), .busy(busy), .done(done),
        .sqrt(sqrt), .rem(rem), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sqrt", 64'(sqrt), 64'(e.s));
                chk("rem", 64'(rem), 64'(e.r));
                chk("err", 64'(err), 64'(e.e));
            end
        end
    end

    task automatic issue(input logic [63:0] x, input int nb, input bit rnd);
        xin = x; nbits = NW'(nb); round = rnd; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Counts edges from the accept edge until done shows, and busy samples on the way.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clock); #1;
            lat++;
            if (busy) bc++;
        end
    endtask

    task automatic run(input logic [63:0] x, input int nb, input bit rnd,
                       input logic [31:0] es, input logic [32:0] er, input bit ee, input int elat);
        int lat, bc;
        exp_t e;
        e = '{es, er, ee};
        sb.push_back(e);
        issue(x, nb, rnd);
        wait_done(lat, bc);
        chk("latency", 64'(lat), 64'(elat));
        chk("busy_cycles", 64'(bc), 64'(elat));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, bc;
        exp_t e;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_sqrt", 64'(sqrt), 0);
        chk("rst_rem", 64'(rem), 0);
        chk("rst_err", 64'(err), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        run(64'd144, 8, 1'b0, 32'd12, 33'd0, 1'b0, 5);
        run(64'd20, 6, 1'b0, 32'd4, 33'd4, 1'b0, 4);
        run(64'd20, 6, 1'b1, 32'd4, 33'd4, 1'b0, 4);
        run(64'h1F4, 7, 1'b1, 32'd16, 33'd19, 1'b0, 5);
        run(64'h1F4, 7, 1'b0, 32'd15, 33'd19, 1'b0, 5);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b0, 33);
        run(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 1'b1, 33);
        run(64'd144, 100, 1'b0, 32'd12, 33'd0, 1'b1, 33);
        run(64'd99, 8, 1'b1, 32'd10, 33'd18, 1'b0, 5);

        // Held results: no new done, outputs unchanged.
        repeat (4) @(posedge clock);
        #1;
        chk("hold_sqrt", 64'(sqrt), 64'd10);
        chk("hold_rem", 64'(rem), 64'd18);

        // Start while busy is ignored; a start in the done cycle is accepted.
        e = '{32'd12, 33'd0, 1'b0};
        sb.push_back(e);
        issue(64'd144, 8, 1'b0);
        @(posedge clock); #1;
        issue(64'd9, 4, 1'b0);
        wait_done(lat, bc);
        chk("ign_done_seen", 64'(done), 1);
        e = '{32'd3, 33'd0, 1'b0};
        sb.push_back(e);
        issue(64'd9, 4, 1'b0);
        wait_done(lat, bc);
        chk("b2b_latency", 64'(lat), 64'd3);

        // Reset in the middle of RUN discards the operation.
        issue(64'd10000, 16, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_sqrt", 64'(sqrt), 0);
        chk("mid_rst_rem", 64'(rem), 0);
        chk("mid_rst_err", 64'(err), 0);
        reset = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        chk("mid_rst_nodone", 64'(done), 0);
        run(64'd10000, 16, 1'b0, 32'd100, 33'd0, 1'b0, 9);

        repeat (3) @(posedge clock);
        #1;
        chk("sb_empty", 64'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/psdsqrt_seq.md
# psdsqrt_seq

Parametrised sequential integer square-root unit. It computes floor(sqrt(x)) and the remainder x − root² for an unsigned operand of run-time-selectable width up to XW bits, producing one root bit per clock. It adds a start/busy/done handshake, an optional round-to-nearest result and an input error flag. It is the datapath's general-purpose square-root engine and replaces fixed-width multiplier-based iteration with a shift/subtract (non-restoring-free, restoring) recurrence.

## Interface
- XW, 64: maximum operand width in bits; must be even, ≥ 4.
- NW, $clog2(XW)+1: width of the nbits port (derived, not overridden).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only when busy=0.
- nbits  in  NW  active operand width N, sampled with start.
- xin  in  XW  operand; bits at or above N are ignored (masked).
- round  in  1  sampled with start; 1 = round-to-nearest, 0 = floor.
- busy  out  1  high from the edge that accepts start until the edge that raises done.
- done  out  1  one-cycle pulse when sqrt/rem/err are valid.
- sqrt  out  XW/2  result root, zero-extended; held until the next done.
- rem  out  XW/2+1  x − floor_root², always relative to the floor root; held until the next done.
- err  out  1  nbits was 0 or > XW for this result; held with sqrt.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, start=1: latch x = xin masked to N bits and latch round. N = nbits rounded up to even. If nbits = 0 or nbits > XW, use N = XW and set pending err. Clear the root and remainder accumulators, load iteration count K = N/2, then go to RUN.
- RUN, each cycle:
  - Shift the next two MSBs of x (from position N−1 downward) into the partial remainder.
  - Trial value t = (root<<2)|1.
  - If partial remainder ≥ t: subtract t and shift a 1 into root; otherwise shift a 0 into root.
  - Decrement K. Go to FIN when K reaches 0 after this iteration.
- FIN:
  - rem ← partial remainder.
  - If round=1 and rem > root: sqrt ← root+1, saturating to all-ones in XW/2 bits.
  - Otherwise sqrt ← root.
  - err ← pending err; done=1 for this cycle; go to IDLE.
- Arithmetic: the partial remainder is XW/2+2 bits wide and never negative after the compare. The final rem ≤ 2·root.
- Start while busy=1 is ignored, with no queueing.
- Reset in any state: state=IDLE, busy=0, done=0, sqrt=0, rem=0, err=0. Any in-flight operation is discarded and no done is produced.

## Timing
- Reset values: busy=0, done=0, sqrt=0, rem=0, err=0.
- Start accepted at edge E0.
  - busy=1 from E0.
  - RUN occupies edges E1..E(N/2).
  - FIN registers the outputs at edge E(N/2+1).
  - done is high for exactly the one cycle following E(N/2+1); busy falls at that same edge.
- Latency is N/2+1 cycles, e.g. 5 cycles for N=8 and 33 cycles for N=64.
- Back-to-back: start may be asserted in the done cycle and is accepted at the next edge. Minimum issue interval is N/2+2 cycles.
- Outputs change only at a FIN edge or at reset.

## Test plan
- x=144, nbits=8, round=0 → done 5 cycles after the start edge; sqrt=12, rem=0, err=0; busy high for exactly 5 cycles.
- x=20, nbits=6 → sqrt=4, rem=4. Repeat with round=1 → sqrt=4 (rem not > root).
- xin=0x1F4, nbits=7, round=1 → N=8, x masked to 244 → rem=19, sqrt=16 (rounded up from 15). Same stimulus with round=0 → sqrt=15.
- xin=all-ones, nbits=64, round=1 → sqrt=0xFFFFFFFF (saturated), rem=0x1FFFFFFFE, done after 33 cycles. Same with nbits=0 → identical result plus err=1.
- Start x=144 (N=8), assert start again with x=9 two cycles later → second request ignored; single done with sqrt=12. Then assert start in the done cycle with x=9, nbits=4 → sqrt=3, rem=0.
- Start x=10000, nbits=16, assert reset at the 4th RUN cycle → all outputs 0, no done pulse. A new start after reset computes sqrt=100, rem=0.
